// File: rtl/ycocg_csc_pkg.sv
// Shared definitions for the YCoCg-R colour-space converter:
// beat mode encodings, container width and the unsigned saturation helper.
package ycocg_csc_pkg;

    localparam logic [1:0] CSC_FWD = 2'd0;
    localparam logic [1:0] CSC_INV = 2'd1;
    localparam logic [1:0] CSC_BYP = 2'd2;

    function automatic int cw(input int bpc);
        return bpc + 2;
    endfunction

    // Saturate a signed value into [0, 2^bpc-1]. The result is never wider than bpc bits.
    function automatic logic [31:0] clip_u(input logic signed [31:0] x, input int bpc);
        logic signed [31:0] max_val;
        logic [31:0]        res;
        max_val = (32'sd1 <<< bpc) - 32'sd1;
        if (x < 32'sd0) begin
            res = '0;
        end else if (x > max_val) begin
            res = max_val;
        end else begin
            res = x;
        end
        return res;
    endfunction

endpackage

// File: rtl/ycocg_lift_px.sv
// One pixel of the YCoCg-R lifting datapath, purely combinational:
// the first-stage half for the incoming beat and the second-stage half for the registered beat.
module ycocg_lift_px
    import ycocg_csc_pkg::*;
#(
    parameter int BPC = 12,
    localparam int CW = cw(BPC)
) (
    input  logic [1:0]      s1_mode,
    input  logic [3*CW-1:0] s1_in,
    output logic [3*CW-1:0] s1_out,
    input  logic [1:0]      s2_mode,
    input  logic [3*CW-1:0] s2_in,
    output logic [3*CW-1:0] s2_out,
    output logic            s2_clip
);

    localparam int WW = CW + 1;
    localparam int WX = CW + 2;
    localparam logic signed [WX-1:0] MAXV = WX'((1 << BPC) - 1);

    logic signed [WW-1:0] r1, b1, y1, cg1, co_f;
    logic signed [WW-1:0] t_f2, g_f2, cg_f;
    logic signed [WX-1:0] t_i2, co_i2, cg_i2, g_i, b_i, r_i;

    // FWD reads unsigned RGB from the low BPC bits; INV reads signed YCoCg containers.
    assign r1   = $signed({{(WW-BPC){1'b0}}, s1_in[0 +: BPC]});
    assign b1   = $signed({{(WW-BPC){1'b0}}, s1_in[2*CW +: BPC]});
    assign y1   = $signed({s1_in[CW-1], s1_in[0 +: CW]});
    assign cg1  = $signed({s1_in[3*CW-1], s1_in[2*CW +: CW]});
    assign co_f = r1 - b1;

    always_comb begin
        s1_out = s1_in;
        case (s1_mode)
            CSC_FWD: s1_out = {{(CW-BPC){1'b0}}, s1_in[CW +: BPC],
                               CW'(b1 + (co_f >>> 1)), co_f[CW-1:0]};
            CSC_INV: s1_out = {s1_in[2*CW +: CW], s1_in[CW +: CW],
                               CW'(y1 - (cg1 >>> 1))};
            default: s1_out = s1_in;
        endcase
    end

    assign t_f2  = $signed({s2_in[2*CW-1], s2_in[CW +: CW]});
    assign g_f2  = $signed({s2_in[3*CW-1], s2_in[2*CW +: CW]});
    assign cg_f  = g_f2 - t_f2;

    // Inverse results carry two guard bits so out-of-range values saturate instead of wrapping.
    assign t_i2  = $signed({{2{s2_in[CW-1]}},   s2_in[0 +: CW]});
    assign co_i2 = $signed({{2{s2_in[2*CW-1]}}, s2_in[CW +: CW]});
    assign cg_i2 = $signed({{2{s2_in[3*CW-1]}}, s2_in[2*CW +: CW]});
    assign g_i   = cg_i2 + t_i2;
    assign b_i   = t_i2 - (co_i2 >>> 1);
    assign r_i   = b_i + co_i2;

    always_comb begin
        s2_out  = s2_in;
        s2_clip = 1'b0;
        case (s2_mode)
            CSC_FWD: s2_out = {cg_f[CW-1:0], s2_in[0 +: CW], CW'(t_f2 + (cg_f >>> 1))};
            CSC_INV: begin
                s2_out  = {CW'(clip_u(32'(b_i), BPC)),
                           CW'(clip_u(32'(g_i), BPC)),
                           CW'(clip_u(32'(r_i), BPC))};
                s2_clip = r_i[WX-1] || (r_i > MAXV) ||
                          g_i[WX-1] || (g_i > MAXV) ||
                          b_i[WX-1] || (b_i > MAXV);
            end
            default: s2_out = s2_in;
        endcase
    end

endmodule

// File: rtl/ycocg_csc_pipe.sv
// Two-stage RGB <-> YCoCg-R lifting converter, PPC pixels per beat,
// valid/ready handshake with full back-pressure and per-beat mode.
module ycocg_csc_pipe
    import ycocg_csc_pkg::*;
#(
    parameter int BPC = 12,
    parameter int PPC = 2,
    localparam int CW = cw(BPC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic                  in_last,
    input  logic [PPC*3*CW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_mode,
    output logic                  out_last,
    output logic [PPC*3*CW-1:0]   out_data,
    output logic [PPC-1:0]        out_clip
);

    localparam int DW = PPC * 3 * CW;

    logic          v1, v2, en1, en2;
    logic [1:0]    s1_mode;
    logic          s1_last;
    logic [DW-1:0] s1_data, s1_next, s2_next;
    logic [PPC-1:0] clip_next;

    // A stage advances when it is empty or its successor advances; no skid buffer.
    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v2;

    for (genvar p = 0; p < PPC; p++) begin : g_px
        ycocg_lift_px #(.BPC(BPC)) u_px (
            .s1_mode (in_mode),
            .s1_in   (in_data[p*3*CW +: 3*CW]),
            .s1_out  (s1_next[p*3*CW +: 3*CW]),
            .s2_mode (s1_mode),
            .s2_in   (s1_data[p*3*CW +: 3*CW]),
            .s2_out  (s2_next[p*3*CW +: 3*CW]),
            .s2_clip (clip_next[p])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_mode <= '0;
            s1_last <= 1'b0;
            s1_data <= '0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_last <= in_last;
                s1_data <= s1_next;
            end
        end
    end

    // Output registers only load with a real beat, so they hold steady while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2       <= 1'b0;
            out_mode <= '0;
            out_last <= 1'b0;
            out_data <= '0;
            out_clip <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                out_mode <= s1_mode;
                out_last <= s1_last;
                out_data <= s2_next;
                out_clip <= clip_next;
            end
        end
    end

endmodule

// File: tb/tb_ycocg_csc_pipe.sv
// Self-checking bench for ycocg_csc_pipe: integer reference model plus scoreboard,
// directed vectors with hand-computed values, back-pressure and mid-stream reset.
module tb_ycocg_csc_pipe;

    localparam int BPC = 12;
    localparam int PPC = 2;
    localparam int CW  = BPC + 2;
    localparam int DW  = PPC * 3 * CW;
    localparam int MAXV = (1 << BPC) - 1;
    localparam logic [1:0] M_FWD = 2'd0;
    localparam logic [1:0] M_INV = 2'd1;
    localparam logic [1:0] M_BYP = 2'd2;

    typedef struct packed {
        logic [1:0]     mode;
        logic           last;
        logic [DW-1:0]  data;
        logic [PPC-1:0] clip;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_last;
    logic [1:0]     in_mode;
    logic [DW-1:0]  in_data;
    logic           out_valid, out_ready, out_last;
    logic [1:0]     out_mode;
    logic [DW-1:0]  out_data;
    logic [PPC-1:0] out_clip;

    int    compared   = 0;
    int    mismatched = 0;
    beat_t expq[$];
    logic  held = 1'b0;
    logic [DW+PPC+3:0] held_snap;
    logic  lb_done;

    ycocg_csc_pipe #(.BPC(BPC), .PPC(PPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_clip  (out_clip)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [CW-1:0] cwv(input int v);
        return CW'(v);
    endfunction

    function automatic int fld(input logic [DW-1:0] d, input int p, input int c);
        return int'($signed(d[(3*p+c)*CW +: CW]));
    endfunction

    function automatic int satU(input int x);
        if (x < 0) return 0;
        if (x > MAXV) return MAXV;
        return x;
    endfunction

    function automatic logic [DW-1:0] mk(input int a0, input int a1, input int a2,
                                         input int b0, input int b1, input int b2);
        logic [DW-1:0] d;
        d = '0;
        d[0*CW +: CW] = CW'(a0);
        d[1*CW +: CW] = CW'(a1);
        d[2*CW +: CW] = CW'(a2);
        d[3*CW +: CW] = CW'(b0);
        d[4*CW +: CW] = CW'(b1);
        d[5*CW +: CW] = CW'(b2);
        return d;
    endfunction

    function automatic logic [DW-1:0] randRgb();
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < 3 * PPC; k++) d[k*CW +: CW] = CW'($urandom_range(0, MAXV));
        return d;
    endfunction

    function automatic logic [DW-1:0] randRaw();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Reference: the lifting equations evaluated on plain integers, with saturation on inverse.
    function automatic beat_t model(input logic [1:0] mode, input logic last, input logic [DW-1:0] din);
        beat_t b;
        int r, g, bl, y, co, cg, t;
        b.mode = mode;
        b.last = last;
        b.data = din;
        b.clip = '0;
        for (int p = 0; p < PPC; p++) begin
            if (mode == M_FWD) begin
                r  = int'(din[(3*p+0)*CW +: BPC]);
                g  = int'(din[(3*p+1)*CW +: BPC]);
                bl = int'(din[(3*p+2)*CW +: BPC]);
                co = r - bl;
                t  = bl + (co >>> 1);
                cg = g - t;
                y  = t + (cg >>> 1);
                b.data[(3*p+0)*CW +: CW] = CW'(y);
                b.data[(3*p+1)*CW +: CW] = CW'(co);
                b.data[(3*p+2)*CW +: CW] = CW'(cg);
            end else if (mode == M_INV) begin
                y  = fld(din, p, 0);
                co = fld(din, p, 1);
                cg = fld(din, p, 2);
                t  = y - (cg >>> 1);
                g  = cg + t;
                bl = t - (co >>> 1);
                r  = bl + co;
                b.clip[p] = (satU(r) != r) || (satU(g) != g) || (satU(bl) != bl);
                b.data[(3*p+0)*CW +: CW] = CW'(satU(r));
                b.data[(3*p+1)*CW +: CW] = CW'(satU(g));
                b.data[(3*p+2)*CW +: CW] = CW'(satU(bl));
            end
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic last,
                                 input logic [DW-1:0] data, output int waits);
        in_valid = 1'b1;
        in_mode  = mode;
        in_last  = last;
        in_data  = data;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", waits);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: on every negedge, check a consumed beat, check stall stability, record accepts.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            expq.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                checkOutput("stall_hold", {out_valid, out_mode, out_last, out_clip, out_data}, held_snap);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_beat: got out_data %0h, expected no beat", out_data);
                end else begin
                    e = expq.pop_front();
                    checkOutput("beat_data", out_data, e.data);
                    checkOutput("beat_mode", out_mode, e.mode);
                    checkOutput("beat_last", out_last, e.last);
                    checkOutput("beat_clip", out_clip, e.clip);
                end
            end
            held      = out_valid && !out_ready;
            held_snap = {out_valid, out_mode, out_last, out_clip, out_data};
            if (in_valid && in_ready) expq.push_back(model(in_mode, in_last, in_data));
        end
    end

    initial begin
        int            w;
        beat_t         m;
        beat_t         li;
        logic [DW-1:0] d;
        logic [DW-1:0] sdata [20];
        logic [1:0]    smode [20];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = '0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        lb_done   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_data", out_data, '0);
        checkOutput("reset_out_mode", out_mode, 2'd0);
        checkOutput("reset_out_last", out_last, 1'b0);
        checkOutput("reset_out_clip", out_clip, '0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Forward: pure red plus a mid-range pixel, strict two-cycle latency
        d = mk(4095, 0, 0, 100, 200, 50);
        m = model(M_FWD, 1'b1, d);
        checkOutput("model_fwd_y", m.data[0*CW +: CW], cwv(1023));
        checkOutput("model_fwd_co", m.data[1*CW +: CW], cwv(4095));
        checkOutput("model_fwd_cg", m.data[2*CW +: CW], cwv(-2047));
        checkOutput("model_fwd_y_px1", m.data[3*CW +: CW], cwv(137));
        applyStimulus(M_FWD, 1'b1, d, w);
        @(negedge clk);
        checkOutput("fwd_latency_early", out_valid, 1'b0);
        @(negedge clk);
        checkOutput("fwd_latency", out_valid, 1'b1);
        checkOutput("fwd_y", out_data[0*CW +: CW], cwv(1023));
        checkOutput("fwd_co", out_data[1*CW +: CW], cwv(4095));
        checkOutput("fwd_cg", out_data[2*CW +: CW], cwv(-2047));
        checkOutput("fwd_cg_px1", out_data[5*CW +: CW], cwv(125));
        @(posedge clk);
        #1;

        // Inverse: exact recovery of red; second pixel clips green 6143 -> 4095
        d = mk(1023, 4095, -2047, 4095, 0, 4095);
        m = model(M_INV, 1'b0, d);
        checkOutput("model_inv_clip", m.clip, 2'b10);
        checkOutput("model_inv_r_px1", m.data[3*CW +: CW], cwv(2048));
        applyStimulus(M_INV, 1'b0, d, w);
        @(negedge clk);
        @(negedge clk);
        checkOutput("inv_valid", out_valid, 1'b1);
        checkOutput("inv_r", out_data[0*CW +: CW], cwv(4095));
        checkOutput("inv_g", out_data[1*CW +: CW], cwv(0));
        checkOutput("inv_b", out_data[2*CW +: CW], cwv(0));
        checkOutput("inv_r_px1", out_data[3*CW +: CW], cwv(2048));
        checkOutput("inv_g_px1", out_data[4*CW +: CW], cwv(4095));
        checkOutput("inv_b_px1", out_data[5*CW +: CW], cwv(2048));
        checkOutput("inv_clip", out_clip, 2'b10);
        @(posedge clk);
        #1;

        // 20-beat stream with a 5-cycle downstream stall
        for (int i = 0; i < 20; i++) begin
            smode[i] = 2'($urandom_range(0, 3));
            if (smode[i] == M_INV) begin
                m = model(M_FWD, 1'b0, randRgb());
                sdata[i] = m.data;
            end else begin
                sdata[i] = randRaw();
            end
        end
        fork
            begin
                int wp;
                for (int i = 0; i < 20; i++) applyStimulus(smode[i], (i % 5) == 4, sdata[i], wp);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                checkOutput("stall_in_ready", in_ready, 1'b0);
                checkOutput("stall_out_valid", out_valid, 1'b1);
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Loopback: FWD then INV of the model's YCoCg, under random back-pressure
        fork
            begin
                int wl;
                beat_t f;
                logic [DW-1:0] x;
                for (int i = 0; i < 150; i++) begin
                    x  = randRgb();
                    f  = model(M_FWD, 1'b0, x);
                    li = model(M_INV, 1'b0, f.data);
                    checkOutput("model_loopback", {li.clip, li.data}, {2'b00, x});
                    applyStimulus(M_FWD, (i % 8) == 7, x, wl);
                    applyStimulus(M_INV, 1'b0, f.data, wl);
                end
                lb_done = 1'b1;
            end
            begin
                while (!lb_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Alternating FWD/INV/BYPASS with no bubbles
        for (int i = 0; i < 12; i++) begin
            if ((i % 3) == 1) begin
                m = model(M_FWD, 1'b0, randRgb());
                d = m.data;
            end else begin
                d = randRaw();
            end
            applyStimulus(2'(i % 3), (i % 3) == 2, d, w);
            checkOutput("no_bubble", w, 0);
        end
        repeat (4) @(posedge clk);
        #1;

        // Reset with two beats in flight
        applyStimulus(M_BYP, 1'b1, randRaw(), w);
        applyStimulus(M_FWD, 1'b0, randRgb(), w);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("flush_out_valid", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        applyStimulus(M_INV, 1'b1, mk(1023, 4095, -2047, 0, 0, 0), w);
        @(negedge clk);
        checkOutput("post_reset_latency_early", out_valid, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_latency", out_valid, 1'b1);
        checkOutput("post_reset_r", out_data[0*CW +: CW], cwv(4095));

        repeat (6) @(negedge clk);
        checkOutput("queue_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ycocg_csc_pipe.md
# ycocg_csc_pipe

Parametrised, pipelined colour-space converter for the pixel datapath. It converts PPC pixels per beat between RGB and YCoCg-R using the reversible lifting transform. The mode is selected per beat: forward, inverse or bypass. Output is clipped in inverse mode. It sits between the source-pixel unpacker and the encoder front end in forward mode, and between the decoder reconstruction and the pixel output in inverse mode. It has a valid/ready handshake with full back-pressure support.

## Interface
Parameters:
- BPC, 12: bits per RGB component, range 8..14.
- PPC, 2: pixels per beat.
- CW, BPC+2: container width per component. Derived; not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat when in_valid && in_ready.
- in_mode  in  2  beat mode: 0 = FWD (RGB→YCoCg), 1 = INV (YCoCg→RGB), 2 = BYPASS, 3 = reserved (treated as BYPASS).
- in_last  in  1  end-of-line sideband, passed through.
- in_data  in  PPC*3*CW  pixel p, component c at bits [(3p+c)*CW +: CW].
  - FWD: c = 0/1/2 is R/G/B, unsigned in low BPC bits; upper 2 bits ignored.
  - INV: c = 0/1/2 is Y/Co/Cg, signed CW.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_mode  out  2  mode of the output beat.
- out_last  out  1  delayed in_last.
- out_data  out  PPC*3*CW  same packing as in_data.
  - FWD: Y/Co/Cg, signed CW.
  - INV: R/G/B, zero-extended BPC.
  - BYPASS: in_data copied unchanged.
- out_clip  out  PPC  per-pixel flag: an INV component was clipped.

## Operation
- Forward transform, all arithmetic signed CW, `>>>` is arithmetic shift (floor):
  - co = r − b
  - t = b + (co>>>1)
  - cg = g − t
  - y = t + (cg>>>1)
- Inverse transform:
  - t = y − (cg>>>1)
  - g = cg + t
  - b = t − (co>>>1)
  - r = b + co
  - Each of r, g, b is clipped to [0, 2^BPC−1].
  - out_clip[p] = OR of the three clip events for pixel p.
- Intermediate widths: compute in CW+1 bits, then truncate to CW. For legal inputs this truncation is lossless. FWD(INV(x)) == x bit-exact whenever no clipping occurred.
- Stage split:
  - S1 registers FWD {co, t, g} or INV {t, co, cg}.
  - S2 registers the final three components and clip flags.
  - BYPASS data rides both stages unchanged.
- mode and last travel with their beat through both stages. Mode may change on every beat with no bubble.
- out_clip = 0 for FWD and BYPASS beats.

## Timing
- Latency: 2 cycles from accept to out_valid, with no stalls. Throughput: 1 beat/cycle.
- Stage enables:
  - en2 = !v2 || out_ready
  - en1 = !v1 || en2
  - in_ready = en1, combinational from out_ready. No skid buffer.
- While out_valid && !out_ready: out_data, out_mode, out_last and out_clip hold stable.
- At most 2 beats are buffered. No beat is dropped or duplicated.
- in_valid with !in_ready: the beat is not captured. The source must hold it.
- Reset:
  - v1, v2 = 0, out_valid = 0, out_data = 0, out_mode = 0, out_last = 0, out_clip = 0.
  - in_ready = 1 from the first cycle after reset deasserts (combinational: 1 while rst, because v1 = 0).
- Reset mid-stream discards all in-flight beats. No output is produced for them.
- Simultaneous accept and emit in a full pipe is legal and sustains 1 beat/cycle.

## Structure
- Package ycocg_csc_pkg:
  - mode localparams CSC_FWD = 2'd0, CSC_INV = 2'd1, CSC_BYP = 2'd2;
  - function cw(bpc) = bpc+2;
  - clip function clip_u(x, bpc).
- Sub-module ycocg_lift_px:
  - purely combinational, one pixel;
  - outputs the S1 and S2 halves for a given mode;
  - instantiated PPC times;
  - the top module owns the registers and the handshake.

## Test plan
- FWD, BPC=12, pixel R=4095, G=0, B=0 → Y=1023, Co=4095, Cg=−2047; out_valid exactly 2 cycles after accept.
- INV, Y=1023, Co=4095, Cg=−2047 → R=4095, G=0, B=0, clip=0. Random 10k-beat FWD→INV loopback is bit-exact for BPC=8 and BPC=12.
- INV, Y=4095, Co=0, Cg=4095 → G clipped 6143→4095, R=B=2048, out_clip[p]=1.
- Continuous stream of 20 beats; out_ready low for 5 cycles mid-stream:
  - in_ready drops once 2 beats are held;
  - outputs stay stable while stalled;
  - all 20 beats arrive in order, with last and mode intact.
- Beats alternate FWD/INV/BYPASS every cycle → each beat is converted per its own mode; BYPASS data is unchanged; no bubbles.
- rst asserted for 1 cycle with 2 beats in flight → out_valid=0 next cycle; those beats are never emitted; the next accepted beat appears 2 cycles after accept.
